// File: rtl/stat_fifo_rr_reader.sv
// Round-robin drain controller: pops bursts of up to MAX_BURST words from a bank of
// showahead FIFOs and merges them into one registered valid/ready stream tagged by port.
module stat_fifo_rr_reader #(
    parameter int PORTS     = 4,
    parameter int DWIDTH    = 64,
    parameter int MAX_BURST = 8,
    localparam int PW       = $clog2(PORTS)
) (
    input  logic                    clk_i,
    input  logic                    rst_n_i,
    input  logic                    en_i,
    input  logic [PORTS-1:0]        fifo_empty_i,
    input  logic [PORTS*DWIDTH-1:0] fifo_data_i,
    output logic [PORTS-1:0]        fifo_rd_req_o,
    output logic [DWIDTH-1:0]       out_data_o,
    output logic [PW-1:0]           out_port_o,
    output logic                    out_valid_o,
    input  logic                    out_ready_i,
    output logic                    busy_o
);

    typedef enum logic {
        IDLE,
        BURST
    } state_t;

    state_t        state;
    logic [PW-1:0] rr_ptr;
    logic [PW-1:0] cur;
    logic [PW-1:0] next_ptr;
    logic [PW-1:0] grant_port;
    logic          grant_found;
    logic [7:0]    burst_cnt;
    logic          load_en;
    logic          cur_empty;
    logic          pop;
    logic          burst_last;

    assign load_en    = !out_valid_o || out_ready_i;
    assign cur_empty  = fifo_empty_i[cur];
    assign pop        = (state == BURST) && load_en && !cur_empty;
    assign burst_last = (burst_cnt == 8'(MAX_BURST - 1));
    assign next_ptr   = (cur == PW'(PORTS - 1)) ? '0 : cur + 1'b1;
    assign busy_o     = (state == BURST);

    // First non-empty port at or above rr_ptr, wrapping around the bank.
    always_comb begin
        int idx;
        grant_found = 1'b0;
        grant_port  = '0;
        idx         = 0;
        for (int i = 0; i < PORTS; i++) begin
            idx = int'(rr_ptr) + i;
            if (idx >= PORTS) idx = idx - PORTS;
            if (!grant_found && !fifo_empty_i[idx]) begin
                grant_found = 1'b1;
                grant_port  = PW'(idx);
            end
        end
    end

    always_comb begin
        fifo_rd_req_o = '0;
        if (pop) fifo_rd_req_o[cur] = 1'b1;
    end

    // Empty exit takes priority: no pop can happen in the cycle empty is seen.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state       <= IDLE;
            rr_ptr      <= '0;
            cur         <= '0;
            burst_cnt   <= '0;
            out_data_o  <= '0;
            out_port_o  <= '0;
            out_valid_o <= 1'b0;
        end else begin
            if (pop) begin
                out_data_o  <= fifo_data_i[cur*DWIDTH +: DWIDTH];
                out_port_o  <= cur;
                out_valid_o <= 1'b1;
            end else if (out_ready_i) begin
                out_valid_o <= 1'b0;
            end

            case (state)
                IDLE: begin
                    if (en_i && grant_found) begin
                        cur       <= grant_port;
                        burst_cnt <= '0;
                        state     <= BURST;
                    end
                end
                BURST: begin
                    if (cur_empty) begin
                        rr_ptr <= next_ptr;
                        state  <= IDLE;
                    end else if (load_en) begin
                        burst_cnt <= burst_cnt + 8'd1;
                        if (burst_last) begin
                            rr_ptr <= next_ptr;
                            state  <= IDLE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_stat_fifo_rr_reader.sv
// Bench for stat_fifo_rr_reader: behavioural showahead FIFOs feed the DUT, and an
// accept log of {port, data} is compared against hand-derived sequences.
module tb_stat_fifo_rr_reader;

    localparam int PORTS = 4;
    localparam int DW    = 16;
    localparam int MB    = 4;
    localparam int DEPTH = 64;

    logic                clk;
    logic                rst_n;
    logic                en;
    logic [PORTS-1:0]    fifo_empty;
    logic [PORTS*DW-1:0] fifo_data;
    logic [PORTS-1:0]    rd_req;
    logic [DW-1:0]       out_data;
    logic [1:0]          out_port;
    logic                out_valid;
    logic                out_ready;
    logic                busy;

    logic [DW-1:0] mem [PORTS][DEPTH];
    int            wr_ptr [PORTS] = '{0, 0, 0, 0};
    int            rd_ptr [PORTS] = '{0, 0, 0, 0};
    int            bad_req_cnt = 0;
    logic [17:0]   log_q [$];

    int tests = 0;
    int fails = 0;

    typedef struct {
        logic          en;
        logic          ready;
        logic          exp_valid;
        logic [1:0]    exp_port;
        logic [DW-1:0] exp_data;
        logic [3:0]    exp_req;
        logic          exp_busy;
    } vec_t;

    vec_t vecs [7];

    stat_fifo_rr_reader #(
        .PORTS(PORTS),
        .DWIDTH(DW),
        .MAX_BURST(MB)
    ) dut (
        .clk_i(clk),
        .rst_n_i(rst_n),
        .en_i(en),
        .fifo_empty_i(fifo_empty),
        .fifo_data_i(fifo_data),
        .fifo_rd_req_o(rd_req),
        .out_data_o(out_data),
        .out_port_o(out_port),
        .out_valid_o(out_valid),
        .out_ready_i(out_ready),
        .busy_o(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    for (genvar k = 0; k < PORTS; k++) begin : g_fifo
        assign fifo_empty[k]          = (rd_ptr[k] == wr_ptr[k]);
        assign fifo_data[k*DW +: DW]  = mem[k][rd_ptr[k] % DEPTH];
    end

    // FIFO pops, pop-strobe legality, and the accepted-word log.
    always @(posedge clk) begin
        for (int k = 0; k < PORTS; k++)
            if (rd_req[k]) rd_ptr[k] <= rd_ptr[k] + 1;
        if ((rd_req & fifo_empty) != 4'b0 || $countones(rd_req) > 1 ||
            (rd_req != 4'b0 && (!busy || !rst_n)))
            bad_req_cnt <= bad_req_cnt + 1;
        if (rst_n && out_valid && out_ready)
            log_q.push_back({out_port, out_data});
    end

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog");
    end

    task automatic push(input int p, input logic [DW-1:0] d);
        mem[p][wr_ptr[p] % DEPTH] = d;
        wr_ptr[p] = wr_ptr[p] + 1;
    endtask

    task automatic applyStimulus(input logic e, input logic r);
        en        = e;
        out_ready = r;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        tests++;
        if (actual !== expected) begin
            fails++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    task automatic waitLog(input string name, input int n, input int budget);
        int c = 0;
        while (log_q.size() < n && c < budget) begin
            @(negedge clk);
            c++;
        end
        checkOutput({name, " words arrived"}, 32'(log_q.size() >= n), 32'd1);
        repeat (4) @(negedge clk);
        checkOutput({name, " word count"}, 32'(log_q.size()), 32'(n));
    endtask

    task automatic checkLog(input string name, input int base, input logic [17:0] exp_q [$]);
        for (int i = 0; i < exp_q.size(); i++) begin
            if (base + i < log_q.size())
                checkOutput($sformatf("%s word %0d", name, i), 32'(log_q[base+i]), 32'(exp_q[i]));
            else
                checkOutput($sformatf("%s word %0d missing", name, i), 32'd0, 32'd1);
        end
    endtask

    task automatic waitPops(input int p, input int target, input int budget);
        int c = 0;
        while (rd_ptr[p] < target && c < budget) begin
            @(negedge clk);
            c++;
        end
        checkOutput($sformatf("pops on port %0d reached", p), 32'(rd_ptr[p] >= target), 32'd1);
    endtask

    initial begin
        logic [17:0] exp_q [$];
        int base;
        int pbase;

        // Single-port latency run: port 1 gets A,B,C while idle at row 0.
        vecs[0] = '{1'b1, 1'b1, 1'b0, 2'd0, 16'h0000, 4'b0000, 1'b0};
        vecs[1] = '{1'b1, 1'b1, 1'b0, 2'd0, 16'h0000, 4'b0010, 1'b1};
        vecs[2] = '{1'b1, 1'b1, 1'b1, 2'd1, 16'hA00A, 4'b0010, 1'b1};
        vecs[3] = '{1'b1, 1'b1, 1'b1, 2'd1, 16'hA00B, 4'b0010, 1'b1};
        vecs[4] = '{1'b1, 1'b1, 1'b1, 2'd1, 16'hA00C, 4'b0000, 1'b1};
        vecs[5] = '{1'b1, 1'b1, 1'b0, 2'd0, 16'h0000, 4'b0000, 1'b0};
        vecs[6] = '{1'b1, 1'b1, 1'b0, 2'd0, 16'h0000, 4'b0000, 1'b0};

        rst_n = 1'b1;
        applyStimulus(1'b0, 1'b1);
        #2 rst_n = 1'b0;

        // Reset with every FIFO non-empty.
        @(negedge clk);
        for (int p = 0; p < PORTS; p++) push(p, 16'(16'hB000 + p));
        applyStimulus(1'b1, 1'b1);
        repeat (5) begin
            @(negedge clk);
            #1;
            checkOutput("reset out_valid", 32'(out_valid), 32'd0);
            checkOutput("reset out_data", 32'(out_data), 32'd0);
            checkOutput("reset out_port", 32'(out_port), 32'd0);
            checkOutput("reset busy", 32'(busy), 32'd0);
            checkOutput("reset rd_req", 32'(rd_req), 32'd0);
        end

        // Enable low after reset: no grants.
        @(negedge clk);
        applyStimulus(1'b0, 1'b1);
        rst_n = 1'b1;
        repeat (10) begin
            @(negedge clk);
            #1;
            checkOutput("en=0 busy", 32'(busy), 32'd0);
            checkOutput("en=0 rd_req", 32'(rd_req), 32'd0);
        end
        base = log_q.size();
        applyStimulus(1'b1, 1'b1);
        waitLog("drain after reset", base + 4, 100);
        exp_q = {};
        for (int p = 0; p < PORTS; p++) exp_q.push_back({2'(p), 16'(16'hB000 + p)});
        checkLog("drain after reset", base, exp_q);

        // Table-driven single-port sequence.
        for (int i = 0; i < 7; i++) begin
            @(negedge clk);
            if (i == 0) begin
                push(1, 16'hA00A);
                push(1, 16'hA00B);
                push(1, 16'hA00C);
            end
            applyStimulus(vecs[i].en, vecs[i].ready);
            #1;
            checkOutput($sformatf("vec%0d out_valid", i), 32'(out_valid), 32'(vecs[i].exp_valid));
            checkOutput($sformatf("vec%0d rd_req", i), 32'(rd_req), 32'(vecs[i].exp_req));
            checkOutput($sformatf("vec%0d busy", i), 32'(busy), 32'(vecs[i].exp_busy));
            if (vecs[i].exp_valid) begin
                checkOutput($sformatf("vec%0d out_data", i), 32'(out_data), 32'(vecs[i].exp_data));
                checkOutput($sformatf("vec%0d out_port", i), 32'(out_port), 32'(vecs[i].exp_port));
            end
        end

        // Backpressure mid-burst on port 2, with port 3 waiting its turn.
        @(negedge clk);
        base  = log_q.size();
        pbase = rd_ptr[2];
        for (int i = 0; i < 6; i++) push(2, 16'(16'hD000 + i));
        push(3, 16'hE000);
        push(3, 16'hE001);
        applyStimulus(1'b1, 1'b1);
        waitPops(2, pbase + 2, 20);
        applyStimulus(1'b1, 1'b0);
        #1;
        checkOutput("stall first rd_req", 32'(rd_req), 32'd0);
        repeat (10) begin
            @(negedge clk);
            #1;
            checkOutput("stall rd_req", 32'(rd_req), 32'd0);
            checkOutput("stall out_data", 32'(out_data), 32'hD001);
            checkOutput("stall out_port", 32'(out_port), 32'd2);
            checkOutput("stall out_valid", 32'(out_valid), 32'd1);
            checkOutput("stall busy", 32'(busy), 32'd1);
        end
        checkOutput("stall pop count", 32'(rd_ptr[2] - pbase), 32'd2);
        applyStimulus(1'b1, 1'b1);
        waitLog("backpressure", base + 8, 100);
        exp_q = {};
        for (int i = 0; i < 4; i++) exp_q.push_back({2'd2, 16'(16'hD000 + i)});
        exp_q.push_back({2'd3, 16'hE000});
        exp_q.push_back({2'd3, 16'hE001});
        exp_q.push_back({2'd2, 16'hD004});
        exp_q.push_back({2'd2, 16'hD005});
        checkLog("backpressure", base, exp_q);

        // Reset after two pops from port 3; port 1 becomes ready meanwhile.
        @(negedge clk);
        base  = log_q.size();
        pbase = rd_ptr[3];
        for (int i = 0; i < 5; i++) push(3, 16'(16'hF000 + i));
        push(1, 16'h1100);
        applyStimulus(1'b1, 1'b1);
        waitPops(3, pbase + 2, 20);
        rst_n = 1'b0;
        #1;
        checkOutput("mid reset out_valid", 32'(out_valid), 32'd0);
        checkOutput("mid reset out_data", 32'(out_data), 32'd0);
        checkOutput("mid reset out_port", 32'(out_port), 32'd0);
        checkOutput("mid reset busy", 32'(busy), 32'd0);
        checkOutput("mid reset rd_req", 32'(rd_req), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        waitLog("reset mid-burst", base + 5, 100);
        exp_q = {};
        exp_q.push_back({2'd3, 16'hF000});
        exp_q.push_back({2'd1, 16'h1100});
        for (int i = 2; i < 5; i++) exp_q.push_back({2'd3, 16'(16'hF000 + i)});
        checkLog("reset mid-burst", base, exp_q);

        // Round robin between ports 0 and 2, five words each.
        @(negedge clk);
        base = log_q.size();
        for (int i = 0; i < 5; i++) begin
            push(0, 16'(16'h0E00 + i));
            push(2, 16'(16'h2E00 + i));
        end
        waitLog("round robin", base + 10, 200);
        exp_q = {};
        for (int i = 0; i < 4; i++) exp_q.push_back({2'd0, 16'(16'h0E00 + i)});
        for (int i = 0; i < 4; i++) exp_q.push_back({2'd2, 16'(16'h2E00 + i)});
        exp_q.push_back({2'd0, 16'h0E04});
        exp_q.push_back({2'd2, 16'h2E04});
        checkLog("round robin", base, exp_q);

        // Enable dropped during a burst: the burst completes, then no new grant.
        @(negedge clk);
        base  = log_q.size();
        pbase = rd_ptr[1];
        for (int i = 0; i < 6; i++) push(1, 16'(16'h5100 + i));
        waitPops(1, pbase + 1, 20);
        applyStimulus(1'b0, 1'b1);
        repeat (12) @(negedge clk);
        #1;
        checkOutput("en drop busy", 32'(busy), 32'd0);
        checkOutput("en drop pop count", 32'(rd_ptr[1] - pbase), 32'd4);
        checkOutput("en drop log count", 32'(log_q.size() - base), 32'd4);
        checkOutput("en drop port1 empty", 32'(fifo_empty[1]), 32'd0);
        applyStimulus(1'b1, 1'b1);
        waitLog("en drop", base + 6, 100);
        exp_q = {};
        for (int i = 0; i < 6; i++) exp_q.push_back({2'd1, 16'(16'h5100 + i)});
        checkLog("en drop", base, exp_q);

        checkOutput("illegal rd_req cycles", 32'(bad_req_cnt), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/stat_fifo_rr_reader.md
# stat_fifo_rr_reader

Round-robin drain controller for a bank of single-clock, showahead status FIFOs. It pops words from up to PORTS FIFOs and merges them into one registered valid/ready output stream, tagging each word with its source port index. The number of consecutive words taken from one FIFO is capped at MAX_BURST. It sits between the per-channel statistics FIFOs and the shared statistics collector/CPU readout path.

## Interface
- PORTS, 4, number of FIFOs served; legal 2..16
- DWIDTH, 64, FIFO word width
- MAX_BURST, 8, max consecutive pops from one port per grant; legal 1..256
- PW (localparam), $clog2(PORTS), port index width

- clk_i  in  1  single clock for the block and all attached FIFOs
- rst_n_i  in  1  asynchronous, active-low reset
- en_i  in  1  enables new grants; an in-progress burst ends normally
- fifo_empty_i  in  PORTS  per-port showahead empty flag
- fifo_data_i  in  PORTS*DWIDTH  per-port showahead q; port k at bits [k*DWIDTH +: DWIDTH]
- fifo_rd_req_o  out  PORTS  per-port pop strobe; combinational, at most one bit high
- out_data_o  out  DWIDTH  registered output word
- out_port_o  out  PW  source port of out_data_o
- out_valid_o  out  1  output word valid
- out_ready_i  in  1  downstream accepts word when out_valid_o && out_ready_i
- busy_o  out  1  high while FSM is in BURST

## Operation
- Output register is loadable when load_en = !out_valid_o || out_ready_i.
- FSM states: IDLE, BURST.
- IDLE: if en_i and any fifo_empty_i bit low, choose the first non-empty port scanning upward from rr_ptr with wrap (rr_ptr, rr_ptr+1, ..., PORTS-1, 0, ...). Register cur = chosen port, clear burst_cnt, go to BURST. No pops in IDLE.
- BURST, pop condition: load_en && !fifo_empty_i[cur]. On pop:
  - assert fifo_rd_req_o[cur]
  - load out_data_o = fifo_data_i[cur], out_port_o = cur, out_valid_o = 1
  - increment burst_cnt
- BURST exit:
  - on a pop with burst_cnt == MAX_BURST-1, or on any BURST cycle with fifo_empty_i[cur] high, go to IDLE.
  - On exit, rr_ptr = cur+1 mod PORTS.
  - Exit on the empty flag happens in the cycle empty is observed; no pop occurs in that cycle.
- When load_en is low in BURST, there are no pops and the FSM holds state. Backpressure never ends a burst.
- An accept without a reload (out_ready_i high, no pop) clears out_valid_o.
- fifo_rd_req_o is never asserted to an empty FIFO, and never outside BURST or to a port other than cur.
- burst_cnt is 8 bits wide. The compare is against MAX_BURST-1, so MAX_BURST=1 gives one pop per grant.
- en_i is sampled only in IDLE.

## Timing
- Reset values:
  - out_data_o = 0, out_port_o = 0, out_valid_o = 0, busy_o = 0, fifo_rd_req_o = 0
  - FSM = IDLE, rr_ptr = 0, cur = 0, burst_cnt = 0
- Latency: empty deasserted at cycle T while in IDLE → grant at T (state BURST at T+1) → pop at T+1 → out_valid_o high at T+2.
- Throughput: one word per cycle within a burst while out_ready_i is high.
- Grant overhead:
  - 1 IDLE cycle per grant when the burst ends on the MAX_BURST limit.
  - 2 cycles (empty-observe + IDLE) when the burst ends on empty.
- While out_valid_o && !out_ready_i, out_data_o and out_port_o are held stable.
- Reset asserted mid-burst: all state returns to reset values immediately. The word in the output register is discarded. FIFO contents are untouched.

## Test plan
- Reset: hold rst_n_i low with all FIFOs non-empty → all outputs 0, no fifo_rd_req_o for the whole reset period.
- Single port: port 1 holds A,B,C, out_ready_i=1, idle at T → out_valid_o at T+2..T+4 with A,B,C and out_port_o=1; fifo_rd_req_o[1] high at T+1..T+3; busy_o falls after empty is observed.
- Round robin: MAX_BURST=4, ports 0 and 2 each hold 5 words → output port order 0,0,0,0,2,2,2,2,0,2, with no loss or duplication.
- Backpressure: out_ready_i low for 10 cycles mid-burst → no pops, out_data_o constant, burst_cnt unchanged; on release the words resume in order.
- Reset mid-burst: drop rst_n_i after 2 pops from port 3 → outputs clear asynchronously. After release, arbitration restarts from port 0 and the remaining port-3 words are drained intact.
- Enable gating: en_i=0 with data in all ports → no grants. Setting en_i=0 during a burst lets that burst complete, then the FSM stays in IDLE.
